// File: rtl/shift_left_seq_unit.sv
// Sequential left shifter: logical, rotate, rotate-through-carry and
// arithmetic modes, one bit per clock, with carry and sticky overflow.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : operation request, sampled only when idle
//   sel1, sel0      : mode {00 lsl, 01 rol, 10 rcl, 11 asl}
//   x, amt, cin     : operand, shift count, carry-in (latched on start)
//   f, cout         : result and carry registers
//   overflow        : sticky arithmetic overflow (mode 11 only)
//   busy, done      : shifting in progress, one-cycle completion pulse
module shift_left_seq_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sel1,
  input  logic             sel0,
  input  logic [WIDTH-1:0] x,
  input  logic [AMT_W-1:0] amt,
  input  logic             cin,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_ROL = 2'b01;
  localparam logic [1:0] M_RCL = 2'b10;
  localparam logic [1:0] M_ASL = 2'b11;

  state_t           state, state_n;
  logic [WIDTH-1:0] f_n;
  logic             cout_n;
  logic             ovf_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [1:0]       mode, mode_n;
  logic             fill;
  logic             msb;
  logic             sign_chg;

  assign msb      = f[WIDTH-1];
  assign sign_chg = f[WIDTH-1] ^ f[WIDTH-2];

  // Bit entering at the LSB for the latched mode.
  always_comb begin
    fill = 1'b0;
    unique case (1'b1)
      (mode == M_ROL): fill = msb;
      (mode == M_RCL): fill = cout;
      default:         fill = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    f_n     = f;
    cout_n  = cout;
    ovf_n   = overflow;
    cnt_n   = cnt;
    mode_n  = mode;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          f_n     = x;
          cnt_n   = amt;
          mode_n  = {sel1, sel0};
          cout_n  = ({sel1, sel0} == M_RCL) ? cin : 1'b0;
          ovf_n   = 1'b0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt != '0) begin
          f_n    = {f[WIDTH-2:0], fill};
          cout_n = msb;
          if (mode == M_ASL && sign_chg) begin
            ovf_n = 1'b1;
          end
          cnt_n  = cnt - 1'b1;
        end else begin
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      f        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      mode     <= M_LSL;
    end else begin
      state    <= state_n;
      f        <= f_n;
      cout     <= cout_n;
      overflow <= ovf_n;
      cnt      <= cnt_n;
      mode     <= mode_n;
    end
  end

endmodule

// File: tb/tb_shift_left_seq_unit.sv
// Self-checking bench for shift_left_seq_unit (WIDTH=8, AMT_W=3).
// Vector table plus hand sequences, expectations via a scoreboard queue.
module tb_shift_left_seq_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel1, sel0;
  logic [7:0] x;
  logic [2:0] amt;
  logic       cin;
  logic [7:0] f;
  logic       cout, overflow, busy, done;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [7:0] f;
    logic       c;
    logic       o;
    int         lat;
  } exp_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] x;
    logic [2:0] amt;
    logic       cin;
    logic [7:0] ef;
    logic       ec;
    logic       eo;
  } vec_t;

  exp_t sbq[$];

  shift_left_seq_unit #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .sel1(sel1), .sel0(sel0), .x(x), .amt(amt), .cin(cin),
    .f(f), .cout(cout), .overflow(overflow),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference: shift one bit at a time.
  function automatic exp_t model(input logic [1:0] sel,
                                 input logic [7:0] xv,
                                 input logic [2:0] av,
                                 input logic ci);
    exp_t e;
    logic [7:0] v;
    logic c, o, top;
    v = xv;
    c = (sel == 2'b10) ? ci : 1'b0;
    o = 1'b0;
    for (int i = 0; i < int'(av); i++) begin
      top = v[7];
      if (sel == 2'b11 && v[7] != v[6]) o = 1'b1;
      case (sel)
        2'b01:   v = {v[6:0], top};
        2'b10:   v = {v[6:0], c};
        default: v = v << 1;
      endcase
      c = top;
    end
    e.f = v; e.c = c; e.o = o; e.lat = int'(av) + 1;
    return e;
  endfunction

  task automatic run_op(input logic [1:0] sel, input logic [7:0] xv,
                        input logic [2:0] av, input logic ci,
                        input logic [7:0] ef, input logic ec,
                        input logic eo);
    exp_t e;
    int   lat;
    bit   seen;
    bit   busy_ok;
    e.f = ef; e.c = ec; e.o = eo; e.lat = int'(av) + 1;
    sbq.push_back(e);
    @(negedge clk);
    sel1 = sel[1]; sel0 = sel[0];
    x = xv; amt = av; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = ~xv; amt = ~av; cin = ~ci;
    sel1 = ~sel[1]; sel0 = ~sel[0];
    busy_ok = busy;
    seen = 0;
    lat = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk); #1;
      lat = i;
      if (done) begin
        seen = 1;
        start = 1'b0;
      end else begin
        if (!busy) busy_ok = 0;
        start = 1'($urandom_range(0, 1));
      end
    end
    e = sbq.pop_front();
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      start = 1'b0;
      return;
    end
    chk("f", 32'(f), 32'(e.f));
    chk("cout", 32'(cout), 32'(e.c));
    chk("overflow", 32'(overflow), 32'(e.o));
    chk("latency", 32'(lat), 32'(e.lat));
    chk("busy_during", 32'(busy_ok), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("f_hold", 32'(f), 32'(e.f));
    chk("cout_hold", 32'(cout), 32'(e.c));
    chk("ovf_hold", 32'(overflow), 32'(e.o));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[13];
    exp_t m;
    bit   sd;
    logic [1:0] rs;
    logic [7:0] rx;
    logic [2:0] ra;
    logic       rc;

    vt[0]  = '{2'b00, 8'h01, 3'd3, 1'b0, 8'h08, 1'b0, 1'b0};
    vt[1]  = '{2'b01, 8'h81, 3'd1, 1'b0, 8'h03, 1'b1, 1'b0};
    vt[2]  = '{2'b10, 8'h80, 3'd2, 1'b1, 8'h03, 1'b0, 1'b0};
    vt[3]  = '{2'b11, 8'h20, 3'd2, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[4]  = '{2'b11, 8'h10, 3'd1, 1'b0, 8'h20, 1'b0, 1'b0};
    vt[5]  = '{2'b10, 8'h5A, 3'd0, 1'b1, 8'h5A, 1'b1, 1'b0};
    vt[6]  = '{2'b00, 8'h5A, 3'd0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vt[7]  = '{2'b00, 8'hFF, 3'd7, 1'b0, 8'h80, 1'b1, 1'b0};
    vt[8]  = '{2'b01, 8'h96, 3'd7, 1'b0, 8'h4B, 1'b1, 1'b0};
    vt[9]  = '{2'b11, 8'hC0, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[10] = '{2'b10, 8'hC1, 3'd3, 1'b0, 8'h0B, 1'b0, 1'b0};
    vt[11] = '{2'b00, 8'h81, 3'd1, 1'b1, 8'h02, 1'b1, 1'b0};
    vt[12] = '{2'b01, 8'h40, 3'd3, 1'b0, 8'h02, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b1;
    sel1 = 1'b0; sel0 = 1'b0;
    x = 8'hAA; amt = 3'd2; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    foreach (vt[i])
      run_op(vt[i].sel, vt[i].x, vt[i].amt, vt[i].cin,
             vt[i].ef, vt[i].ec, vt[i].eo);

    // Rotate-through-carry intermediate step.
    @(negedge clk);
    sel1 = 1'b1; sel0 = 1'b0; x = 8'h80; amt = 3'd2; cin = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rcl_load_f", 32'(f), 32'h80);
    chk("rcl_load_c", 32'(cout), 32'd1);
    @(posedge clk); #1;
    chk("rcl_step1_f", 32'(f), 32'h01);
    chk("rcl_step1_c", 32'(cout), 32'd1);
    @(posedge clk); #1;
    chk("rcl_step2_f", 32'(f), 32'h03);
    chk("rcl_step2_c", 32'(cout), 32'd0);
    @(posedge clk); #1;
    chk("rcl_done", 32'(done), 32'd1);
    @(posedge clk); #1;

    // Ignored second start, then reset at step 3.
    @(negedge clk);
    sel1 = 1'b0; sel0 = 1'b0; x = 8'hFF; amt = 3'd7; cin = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort_step1_f", 32'(f), 32'hFE);
    @(negedge clk);
    start = 1'b1; x = 8'h00; sel0 = 1'b1; amt = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ignore_start_f", 32'(f), 32'hFC);
    chk("ignore_start_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_f", 32'(f), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sd = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) sd = 1;
    end
    chk("no_done_after_abort", 32'(sd), 32'd0);
    run_op(2'b00, 8'h03, 3'd2, 1'b0, 8'h0C, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      rs = 2'($urandom_range(0, 3));
      rx = 8'($urandom_range(0, 255));
      ra = 3'($urandom_range(0, 7));
      rc = 1'($urandom_range(0, 1));
      m = model(rs, rx, ra, rc);
      run_op(rs, rx, ra, rc, m.f, m.c, m.o);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
